// File: rtl/trap_ctrl_pkg.sv
// Shared types and cause encodings for the commit-side trap sequencer.
// The mcause values match the encodings csr_regs writes into mcause.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        TK_EXC,
        TK_MRET,
        TK_CSR
    } trap_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FIRE,
        ST_REDIRECT
    } trap_state_e;

    localparam logic [3:0] MCAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] MCAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] MCAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] MCAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] MCAUSE_ECALL_M        = 4'd11;

    // Priority: instr_misalign > illegal > ecall > load > store.
    function automatic logic [3:0] exc_cause(input logic imis, input logic ill, input logic ecall,
                                             input logic lmis, input logic smis);
        logic [3:0] c;
        c = MCAUSE_STORE_MISALIGN;
        if (imis)       c = MCAUSE_INSTR_MISALIGN;
        else if (ill)   c = MCAUSE_ILLEGAL;
        else if (ecall) c = MCAUSE_ECALL_M;
        else if (lmis)  c = MCAUSE_LOAD_MISALIGN;
        else if (smis)  c = MCAUSE_STORE_MISALIGN;
        return c;
    endfunction

    // One-hot ordering: {instr_misalign, illegal, ecall, load_misalign, store_misalign}.
    function automatic logic [4:0] cause_onehot(input logic [3:0] cause);
        logic [4:0] oh;
        oh = '0;
        case (cause)
            MCAUSE_INSTR_MISALIGN: oh = 5'b10000;
            MCAUSE_ILLEGAL:        oh = 5'b01000;
            MCAUSE_ECALL_M:        oh = 5'b00100;
            MCAUSE_LOAD_MISALIGN:  oh = 5'b00010;
            MCAUSE_STORE_MISALIGN: oh = 5'b00001;
            default:               oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Commit-side trap sequencer: capture, flush, drain memory, pulse csr_regs,
// then hand the redirect PC to fetch over valid/ready.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic [ILEN-1:0] commit_instr_i,
    input  logic            ecall_i,
    input  logic            instr_misalign_i,
    input  logic            illegal_i,
    input  logic            load_misalign_i,
    input  logic            store_misalign_i,
    input  logic            mret_i,
    input  logic            csr_wr_i,
    input  logic            mem_busy_i,
    input  logic [XLEN-1:0] csr_next_pc_i,
    output logic            exception_o,
    output logic            ecall_o,
    output logic            instr_misalign_o,
    output logic            illegal_o,
    output logic            load_misalign_o,
    output logic            store_misalign_o,
    output logic            mret_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            mcycle_inc_o,
    output logic            instret_inc_o
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } redirect_t;

    trap_state_e     state_q;
    trap_kind_e      kind_q;
    trap_kind_e      kind_d;
    logic [3:0]      cause_q;
    logic [3:0]      cause_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] trap_pc_q;
    redirect_t       redir_q;
    logic            flush_q;
    logic            exc_q;
    logic            mret_q;
    logic [4:0]      cause_oh_q;
    logic            exc_any;
    logic            event_any;
    logic            unused_instr;

    assign unused_instr = ^commit_instr_i;

    always_comb begin
        exc_any   = ecall_i | instr_misalign_i | illegal_i | load_misalign_i | store_misalign_i;
        event_any = exc_any | mret_i | csr_wr_i;
        kind_d    = exc_any ? TK_EXC : (mret_i ? TK_MRET : TK_CSR);
        cause_d   = exc_cause(instr_misalign_i, illegal_i, ecall_i, load_misalign_i, store_misalign_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            kind_q     <= TK_EXC;
            cause_q    <= '0;
            pc_q       <= '0;
            trap_pc_q  <= '0;
            redir_q    <= '0;
            flush_q    <= 1'b0;
            exc_q      <= 1'b0;
            mret_q     <= 1'b0;
            cause_oh_q <= '0;
        end else begin
            flush_q    <= 1'b0;
            exc_q      <= 1'b0;
            mret_q     <= 1'b0;
            cause_oh_q <= '0;
            trap_pc_q  <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (commit_valid_i && event_any) begin
                        pc_q    <= commit_pc_i;
                        kind_q  <= kind_d;
                        cause_q <= cause_d;
                        flush_q <= 1'b1;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!mem_busy_i) begin
                        state_q   <= ST_FIRE;
                        trap_pc_q <= pc_q;
                        exc_q     <= (kind_q == TK_EXC);
                        mret_q    <= (kind_q == TK_MRET);
                        if (kind_q == TK_EXC) cause_oh_q <= cause_onehot(cause_q);
                    end
                end
                ST_FIRE: begin
                    // csr_regs presents mtvec/mepc during the pulse cycle; CSR writes fall through.
                    state_q       <= ST_REDIRECT;
                    redir_q.valid <= 1'b1;
                    redir_q.pc    <= (kind_q == TK_CSR) ? pc_q + XLEN'(4) : csr_next_pc_i;
                end
                ST_REDIRECT: begin
                    if (redirect_ready_i) begin
                        redir_q.valid <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign exception_o      = exc_q;
    assign instr_misalign_o = cause_oh_q[4];
    assign illegal_o        = cause_oh_q[3];
    assign ecall_o          = cause_oh_q[2];
    assign load_misalign_o  = cause_oh_q[1];
    assign store_misalign_o = cause_oh_q[0];
    assign mret_o           = mret_q;
    assign trap_pc_o        = trap_pc_q;
    assign flush_o          = flush_q;
    assign stall_o          = (state_q != ST_IDLE);
    assign redirect_valid_o = redir_q.valid;
    assign redirect_pc_o    = redir_q.pc;
    assign mcycle_inc_o     = ~reset;
    assign instret_inc_o    = ~reset & commit_valid_i & (state_q == ST_IDLE) & ~exc_any;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed transaction table plus random transactions
// checked cycle by cycle against a timeline model of the trap sequence.
module tb_trap_ctrl;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            commit_valid_i;
    logic [XLEN-1:0] commit_pc_i;
    logic [ILEN-1:0] commit_instr_i;
    logic            ecall_i, instr_misalign_i, illegal_i, load_misalign_i, store_misalign_i;
    logic            mret_i, csr_wr_i, mem_busy_i, redirect_ready_i;
    logic [XLEN-1:0] csr_next_pc_i;
    logic            exception_o, ecall_o, instr_misalign_o, illegal_o, load_misalign_o, store_misalign_o;
    logic            mret_o, flush_o, stall_o, redirect_valid_o, mcycle_inc_o, instret_inc_o;
    logic [XLEN-1:0] trap_pc_o, redirect_pc_o;

    trap_ctrl #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk(clk), .reset(reset),
        .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
        .ecall_i(ecall_i), .instr_misalign_i(instr_misalign_i), .illegal_i(illegal_i),
        .load_misalign_i(load_misalign_i), .store_misalign_i(store_misalign_i),
        .mret_i(mret_i), .csr_wr_i(csr_wr_i), .mem_busy_i(mem_busy_i), .csr_next_pc_i(csr_next_pc_i),
        .exception_o(exception_o), .ecall_o(ecall_o), .instr_misalign_o(instr_misalign_o),
        .illegal_o(illegal_o), .load_misalign_o(load_misalign_o), .store_misalign_o(store_misalign_o),
        .mret_o(mret_o), .trap_pc_o(trap_pc_o), .flush_o(flush_o), .stall_o(stall_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i), .mcycle_inc_o(mcycle_inc_o), .instret_inc_o(instret_inc_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // flags ordering: {instr_misalign, illegal, ecall, load_misalign, store_misalign}
    typedef struct {
        logic [4:0]  flags;
        logic        mret;
        logic        csr;
        logic [63:0] pc;
        logic [63:0] npc;
        int unsigned busy;
        int unsigned rdly;
        logic        exp_exc;
        logic        exp_mret;
        logic [4:0]  exp_cause;
        logic [63:0] exp_rpc;
    } txn_t;

    function automatic txn_t mk(input logic [4:0] f, input logic m, input logic c, input logic [63:0] pc,
                                input logic [63:0] npc, input int unsigned b, input int unsigned r,
                                input logic ee, input logic em, input logic [4:0] ec, input logic [63:0] rpc);
        txn_t x;
        x.flags = f; x.mret = m; x.csr = c; x.pc = pc; x.npc = npc; x.busy = b; x.rdly = r;
        x.exp_exc = ee; x.exp_mret = em; x.exp_cause = ec; x.exp_rpc = rpc;
        return x;
    endfunction

    // Reference: a trap exists if any exception flag is set; the highest-priority flag alone is
    // reported; MRET only when no exception; otherwise a CSR write falls through to pc+4.
    function automatic txn_t model(input txn_t x);
        txn_t y;
        y = x;
        y.exp_exc   = (x.flags != 5'b0);
        y.exp_mret  = !y.exp_exc && x.mret;
        y.exp_cause = 5'b0;
        for (int i = 4; i >= 0; i--) begin
            if (x.flags[i] && y.exp_cause == 5'b0) y.exp_cause = 5'(1 << i);
        end
        y.exp_rpc = (y.exp_exc || y.exp_mret) ? x.npc : x.pc + 64'd4;
        return y;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] cause_out();
        return {instr_misalign_o, illegal_o, ecall_o, load_misalign_o, store_misalign_o};
    endfunction

    task automatic set_cmd(input logic cv, input logic [4:0] f, input logic m, input logic c,
                           input logic [63:0] pc);
        commit_valid_i = cv;
        {instr_misalign_i, illegal_i, ecall_i, load_misalign_i, store_misalign_i} = f;
        mret_i = m; csr_wr_i = c; commit_pc_i = pc; commit_instr_i = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_exc"}, exception_o, 0);
        chk({tag, "_mret"}, mret_o, 0);
        chk({tag, "_cause"}, cause_out(), 0);
        chk({tag, "_flush"}, flush_o, 0);
        chk({tag, "_rvalid"}, redirect_valid_o, 0);
    endtask

    task automatic idle_cycles(input int unsigned n);
        logic cv;
        for (int unsigned k = 0; k < n; k++) begin
            next_cycle();
            cv = 1'($urandom);
            if (cv) set_cmd(1'b1, 5'b0, 1'b0, 1'b0, {$urandom, $urandom});
            else    set_cmd(1'b0, 5'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
            mem_busy_i = 1'($urandom); redirect_ready_i = 1'($urandom);
            @(negedge clk);
            chk("idle_stall", stall_o, 0);
            chk("idle_instret", instret_inc_o, cv);
            chk("idle_mcycle", mcycle_inc_o, 1);
            check_quiet("idle");
        end
    endtask

    task automatic run_txn(input txn_t x);
        int unsigned last;
        logic fire;
        next_cycle();
        set_cmd(1'b1, x.flags, x.mret, x.csr, x.pc);
        csr_next_pc_i = x.npc; mem_busy_i = 1'($urandom); redirect_ready_i = 1'($urandom);
        @(negedge clk);
        chk("ev_stall", stall_o, 0);
        chk("ev_instret", instret_inc_o, !x.exp_exc);
        check_quiet("ev");
        last = 3 + x.busy + x.rdly;
        for (int unsigned t = 1; t <= last; t++) begin
            next_cycle();
            // Upstream keeps presenting junk (including events) while stalled; all must be ignored.
            set_cmd(1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
            mem_busy_i = (t <= x.busy) ? 1'b1 : ((t == x.busy + 1) ? 1'b0 : 1'($urandom));
            redirect_ready_i = (t >= 3 + x.busy) ? (t == last) : 1'($urandom);
            @(negedge clk);
            fire = (t == 2 + x.busy);
            chk("seq_stall", stall_o, 1);
            chk("seq_instret", instret_inc_o, 0);
            chk("seq_mcycle", mcycle_inc_o, 1);
            chk("seq_flush", flush_o, t == 1);
            chk("seq_exc", exception_o, fire && x.exp_exc);
            chk("seq_mret", mret_o, fire && x.exp_mret);
            chk("seq_cause", cause_out(), fire ? x.exp_cause : 5'b0);
            chk("seq_rvalid", redirect_valid_o, t >= 3 + x.busy);
            if (fire) chk("trap_pc", trap_pc_o, x.pc);
            if (t >= 3 + x.busy) chk("redirect_pc", redirect_pc_o, x.exp_rpc);
        end
        next_cycle();
        set_cmd(1'b0, 5'b0, 1'b0, 1'b0, 64'h0);
        redirect_ready_i = 1'b0;
        @(negedge clk);
        chk("end_stall", stall_o, 0);
        chk("end_rvalid", redirect_valid_o, 0);
    endtask

    txn_t tbl[8];
    txn_t rt;
    int unsigned sel;

    initial begin
        tbl[0] = mk(5'b00100, 0, 0, 64'h8000_0010, 64'h8000_0100, 0, 0, 1, 0, 5'b00100, 64'h8000_0100);
        tbl[1] = mk(5'b01010, 0, 0, 64'h1000, 64'h40, 0, 0, 1, 0, 5'b01000, 64'h40);
        tbl[2] = mk(5'b00000, 1, 0, 64'h3000, 64'h2004, 5, 0, 0, 1, 5'b00000, 64'h2004);
        tbl[3] = mk(5'b00000, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h9999, 0, 0, 0, 0, 5'b00000, 64'h0);
        tbl[4] = mk(5'b00001, 0, 0, 64'h3000, 64'h500, 0, 3, 1, 0, 5'b00001, 64'h500);
        tbl[5] = mk(5'b11111, 1, 1, 64'h44, 64'h80, 2, 1, 1, 0, 5'b10000, 64'h80);
        tbl[6] = mk(5'b00000, 1, 1, 64'h120, 64'h7000, 1, 2, 0, 1, 5'b00000, 64'h7000);
        tbl[7] = mk(5'b00011, 0, 1, 64'h200, 64'hA0, 0, 0, 1, 0, 5'b00010, 64'hA0);

        reset = 1'b1;
        set_cmd(1'b0, 5'b0, 1'b0, 1'b0, 64'h0);
        mem_busy_i = 1'b0; redirect_ready_i = 1'b0; csr_next_pc_i = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_mcycle", mcycle_inc_o, 0);
        chk("rst_instret", instret_inc_o, 0);
        chk("rst_trap_pc", trap_pc_o, 0);
        chk("rst_rpc", redirect_pc_o, 0);
        check_quiet("rst");
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_mcycle", mcycle_inc_o, 1);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
            idle_cycles(2);
        end

        // Reset while draining must abort the sequence with no pulse.
        next_cycle();
        set_cmd(1'b1, 5'b00100, 1'b0, 1'b0, 64'h5000);
        mem_busy_i = 1'b1;
        next_cycle();
        set_cmd(1'b0, 5'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("rd_flush", flush_o, 1);
        chk("rd_stall", stall_o, 1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rd_mcycle", mcycle_inc_o, 0);
        next_cycle();
        set_cmd(1'b1, 5'b0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("rd_stall0", stall_o, 0);
        chk("rd_instret0", instret_inc_o, 0);
        chk("rd_mcycle0", mcycle_inc_o, 0);
        check_quiet("rd");
        next_cycle();
        reset = 1'b0; mem_busy_i = 1'b0;
        set_cmd(1'b0, 5'b0, 1'b0, 1'b0, 64'h0);
        idle_cycles(6);
        run_txn(tbl[0]);

        for (int n = 0; n < 40; n++) begin
            rt.npc = {$urandom, $urandom};
            rt.pc  = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
            rt.busy = $urandom_range(0, 6);
            rt.rdly = $urandom_range(0, 4);
            sel = $urandom_range(0, 2);
            rt.flags = (sel == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
            rt.mret  = (sel == 1) ? 1'b1 : ((sel == 0) ? 1'($urandom) : 1'b0);
            rt.csr   = (sel == 2) ? 1'b1 : 1'($urandom);
            run_txn(model(rt));
            idle_cycles($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
